// File: rtl/genrl_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo read-side stream adapter.
package genrl_fifo_pkg;

   localparam int unsigned BUF_DEPTH_MIN = 2;
   localparam int unsigned BUF_DEPTH_MAX = 8;
   localparam int unsigned STAT_W        = 32;

   // Smallest n with 2**n >= value; returns 0 for value <= 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_stream_rd_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for sync_fifo_stream_rd.
interface sync_fifo_stream_rd_if #(
   parameter int unsigned WIDTH     = 1024,
   parameter int unsigned CNT_WIDTH = 2
);
   logic                 FIFO_RD_EN;
   logic [WIDTH-1:0]     FIFO_DOUT;
   logic                 FIFO_EMPTY;
   logic                 M_VALID;
   logic                 M_READY;
   logic [WIDTH-1:0]     M_DATA;
   logic [CNT_WIDTH-1:0] BUF_CNT;

   modport master (
      output FIFO_RD_EN,
      input  FIFO_DOUT,
      input  FIFO_EMPTY,
      output M_VALID,
      input  M_READY,
      output M_DATA,
      output BUF_CNT
   );

   modport slave (
      input  FIFO_RD_EN,
      output FIFO_DOUT,
      output FIFO_EMPTY,
      input  M_VALID,
      output M_READY,
      input  M_DATA,
      input  BUF_CNT
   );
endinterface

// File: rtl/sync_fifo_skid_buf.sv
// Small circular register buffer with wrapping pointers and occupancy count.
module sync_fifo_skid_buf
   import genrl_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 1024,
   parameter int unsigned DEPTH     = 3,
   parameter int unsigned CNT_WIDTH = clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     data,
   output logic                 valid,
   output logic [CNT_WIDTH-1:0] count
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0] occ_q, occ_d;

   // Wrap by compare so non-power-of-two depths never touch unused slots.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage is intentionally left out of reset; occupancy alone qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign data  = mem_q[rd_ptr_q];
   assign valid = (occ_q != '0);
   assign count = occ_q;

endmodule

// File: rtl/sync_fifo_stream_rd.sv
// Drains a non-FWFT sync_fifo into a valid/ready stream through a credit-checked skid buffer.
// Optional FIFO_RD_STATS_EN adds saturating beat/stall counters (STAT_BEATS, STAT_STALLS).
module sync_fifo_stream_rd
   import genrl_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 1024,
   parameter int unsigned BUF_DEPTH = 3,
   parameter int unsigned CNT_WIDTH = clog2(BUF_DEPTH + 1)
) (
   input  logic                CLK,
   input  logic                RST,
   sync_fifo_stream_rd_if.master bus
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [STAT_W-1:0]   STAT_BEATS,
   output logic [STAT_W-1:0]   STAT_STALLS
`endif
);

   if (BUF_DEPTH < BUF_DEPTH_MIN || BUF_DEPTH > BUF_DEPTH_MAX) begin : g_bad_depth
      $error("sync_fifo_stream_rd: BUF_DEPTH out of range");
   end

   logic                 pend_q;
   logic                 rd_en;
   logic                 pop;
   logic                 buf_valid;
   logic [CNT_WIDTH-1:0] occ;
   logic [CNT_WIDTH:0]   committed;

   // Buffered beats plus the read still in flight must leave room for one more.
   assign committed = {1'b0, occ} + {{CNT_WIDTH{1'b0}}, pend_q};
   assign rd_en     = !RST && !bus.FIFO_EMPTY && (committed < (CNT_WIDTH + 1)'(BUF_DEPTH));

   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= rd_en;
      end
   end

   assign pop = buf_valid && bus.M_READY;

   sync_fifo_skid_buf #(
      .WIDTH     (WIDTH),
      .DEPTH     (BUF_DEPTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_skid_buf (
      .clk       (CLK),
      .rst       (RST),
      .push      (pend_q),
      .push_data (bus.FIFO_DOUT),
      .pop       (pop),
      .data      (bus.M_DATA),
      .valid     (buf_valid),
      .count     (occ)
   );

   assign bus.FIFO_RD_EN = rd_en;
   assign bus.M_VALID    = buf_valid;
   assign bus.BUF_CNT    = occ;

`ifdef FIFO_RD_STATS_EN
   logic [STAT_W-1:0] stat_beats_q;
   logic [STAT_W-1:0] stat_stalls_q;
   logic              stall;

   assign stall = buf_valid && !bus.M_READY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stat_beats_q  <= '0;
         stat_stalls_q <= '0;
      end else begin
         if (pop && (stat_beats_q != '1)) begin
            stat_beats_q <= stat_beats_q + 1'b1;
         end
         if (stall && (stat_stalls_q != '1)) begin
            stat_stalls_q <= stat_stalls_q + 1'b1;
         end
      end
   end

   assign STAT_BEATS  = stat_beats_q;
   assign STAT_STALLS = stat_stalls_q;
`endif

endmodule

// File: tb/tb_sync_fifo_stream_rd.sv
// Bench for sync_fifo_stream_rd attached to a behavioural 16x32 non-FWFT FIFO.
module tb_sync_fifo_stream_rd;

   localparam int unsigned W  = 32;
   localparam int unsigned BD = 3;
   localparam int unsigned CW = 2;
   localparam int unsigned FD = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         fifo_rst = 1'b1;
   logic         wr_en = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         m_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   // Behavioural sync_fifo: registered DOUT, read ignored when empty, write ignored when full.
   logic [W-1:0] fmem [FD];
   logic [3:0]   f_wp = '0;
   logic [3:0]   f_rp = '0;
   int           f_cnt = 0;
   logic [W-1:0] f_dout = '0;

   sync_fifo_stream_rd_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

   assign bus.FIFO_DOUT  = f_dout;
   assign bus.FIFO_EMPTY = (f_cnt == 0);
   assign bus.M_READY    = m_ready;

`ifdef FIFO_RD_STATS_EN
   logic [31:0] stat_beats;
   logic [31:0] stat_stalls;
`endif

   sync_fifo_stream_rd #(
      .WIDTH     (W),
      .BUF_DEPTH (BD),
      .CNT_WIDTH (CW)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .bus         (bus.master)
`ifdef FIFO_RD_STATS_EN
      ,
      .STAT_BEATS  (stat_beats),
      .STAT_STALLS (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      logic do_rd;
      logic do_wr;
      if (fifo_rst) begin
         f_wp  <= '0;
         f_rp  <= '0;
         f_cnt <= 0;
      end else begin
         do_rd = bus.FIFO_RD_EN && (f_cnt != 0);
         do_wr = wr_en && (f_cnt != FD);
         if (do_wr) begin
            fmem[f_wp] <= wr_data;
            f_wp       <= f_wp + 4'd1;
         end
         if (do_rd) begin
            f_dout <= fmem[f_rp];
            f_rp   <= f_rp + 4'd1;
         end
         f_cnt <= f_cnt + int'(do_wr) - int'(do_rd);
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      wr_en    = 1'b0;
      rst      = 1'b1;
      fifo_rst = 1'b1;
      cyc();
      rst      = 1'b0;
      fifo_rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fifo_rst = 1'b1;
      cyc();
      fifo_rst = 1'b0;
      // FIFO fills while the adapter is held in reset; it must stay silent.
      for (int i = 0; i < 7; i++) begin
         wr_en   = (i < 4);
         wr_data = 32'h100 + 32'(i);
         #1;
         total++;
         if (bus.FIFO_RD_EN !== 1'b0 || bus.M_VALID !== 1'b0 || bus.BUF_CNT !== 2'd0) begin
            bad++;
            $display("FAIL reset_hold cyc%0d: rd_en=%b valid=%b cnt=%0d required 0/0/0",
                     i, bus.FIFO_RD_EN, bus.M_VALID, bus.BUF_CNT);
         end
         cyc();
      end
      do_reset();
      #1;
`ifdef FIFO_RD_STATS_EN
      total++;
      if (stat_beats !== 32'd0 || stat_stalls !== 32'd0) begin
         bad++;
         $display("FAIL reset_stats: beats=%0d stalls=%0d required 0/0", stat_beats, stat_stalls);
      end
`endif
   endtask

   task automatic test_latency();
      m_ready = 1'b1;
      wr_en   = 1'b1;
      wr_data = 32'hA5;
      #1;
      total++;
      if (bus.FIFO_RD_EN !== 1'b0) begin
         bad++;
         $display("FAIL lat_c0_rden: got %b required 0", bus.FIFO_RD_EN);
      end
      cyc();
      wr_en = 1'b0;
      #1;
      total++;
      if (bus.FIFO_RD_EN !== 1'b1 || bus.M_VALID !== 1'b0) begin
         bad++;
         $display("FAIL lat_c1: rd_en=%b valid=%b required 1/0", bus.FIFO_RD_EN, bus.M_VALID);
      end
      cyc();
      #1;
      total++;
      if (bus.M_VALID !== 1'b0 || bus.FIFO_RD_EN !== 1'b0) begin
         bad++;
         $display("FAIL lat_c2: valid=%b rd_en=%b required 0/0", bus.M_VALID, bus.FIFO_RD_EN);
      end
      cyc();
      #1;
      total++;
      if (bus.M_VALID !== 1'b1 || bus.M_DATA !== 32'hA5) begin
         bad++;
         $display("FAIL lat_c3: valid=%b data=%0h required 1/a5", bus.M_VALID, bus.M_DATA);
      end
      cyc();
      #1;
      total++;
      if (bus.M_VALID !== 1'b0 || bus.BUF_CNT !== 2'd0) begin
         bad++;
         $display("FAIL lat_c4: valid=%b cnt=%0d required 0/0", bus.M_VALID, bus.BUF_CNT);
      end
   endtask

   task automatic test_streaming();
      int wi = 0;
      int got = 0;
      int first = -1;
      m_ready = 1'b1;
      for (int c = 0; c < 80 && got < 16; c++) begin
         wr_en   = (wi < 16);
         wr_data = 32'(wi);
         if (wi < 16) wi++;
         #1;
         if (bus.M_VALID === 1'b1) begin
            if (first < 0) first = c;
            total++;
            if (bus.M_DATA !== 32'(got) || (c - first) != got) begin
               bad++;
               $display("FAIL stream_beat%0d: data=%0h at offset %0d required %0h at offset %0d",
                        got, bus.M_DATA, c - first, got, got);
            end
            got++;
         end
         cyc();
      end
      wr_en = 1'b0;
      total++;
      if (got != 16) begin
         bad++;
         $display("FAIL stream_count: got %0d beats required 16", got);
      end
   endtask

   task automatic test_backpressure();
      int got = 0;
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'(i);
         cyc();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if (bus.M_VALID !== 1'b1 || bus.M_DATA !== 32'd0) begin
            bad++;
            $display("FAIL bp_hold cyc%0d: valid=%b data=%0h required 1/0", i, bus.M_VALID,
                     bus.M_DATA);
         end
         cyc();
      end
      #1;
      total++;
      if (bus.BUF_CNT !== 2'd3 || f_cnt != 13) begin
         bad++;
         $display("FAIL bp_levels: buf_cnt=%0d fifo_cnt=%0d required 3/13", bus.BUF_CNT, f_cnt);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 60 && got < 16; c++) begin
         #1;
         if (bus.M_VALID === 1'b1) begin
            total++;
            if (bus.M_DATA !== 32'(got)) begin
               bad++;
               $display("FAIL bp_order beat%0d: got %0h required %0h", got, bus.M_DATA, got);
            end
            got++;
         end
         cyc();
      end
      total++;
      if (got != 16) begin
         bad++;
         $display("FAIL bp_count: got %0d beats required 16", got);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q [$];
      int           pushed = 0;
      int           got = 0;
      int           beats = 0;
      int           stalls = 0;
      logic         prev_stall = 1'b0;
      logic [W-1:0] prev_data = '0;
      int           c;
      do_reset();
      for (c = 0; c < 40000 && got < 2000; c++) begin
         wr_en   = (pushed < 2000) && (f_cnt < FD) && ($urandom_range(0, 1) == 1);
         wr_data = $urandom;
         m_ready = ($urandom_range(0, 1) == 1);
         if (wr_en) begin
            exp_q.push_back(wr_data);
            pushed++;
         end
         #1;
         if (bus.FIFO_RD_EN === 1'b1 && bus.FIFO_EMPTY === 1'b1) begin
            bad++;
            total++;
            $display("FAIL rnd_rd_empty cyc%0d: rd_en=1 with empty=1 required rd_en=0", c);
         end
         if (bus.BUF_CNT > 2'(BD)) begin
            bad++;
            total++;
            $display("FAIL rnd_overflow cyc%0d: buf_cnt=%0d required <=%0d", c, bus.BUF_CNT, BD);
         end
         if (prev_stall) begin
            total++;
            if (bus.M_VALID !== 1'b1 || bus.M_DATA !== prev_data) begin
               bad++;
               $display("FAIL rnd_hold cyc%0d: valid=%b data=%0h required 1/%0h", c, bus.M_VALID,
                        bus.M_DATA, prev_data);
            end
         end
         if (bus.M_VALID === 1'b1 && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rnd_extra cyc%0d: got %0h required no beat", c, bus.M_DATA);
            end else begin
               if (bus.M_DATA !== exp_q[0]) begin
                  bad++;
                  $display("FAIL rnd_order beat%0d: got %0h required %0h", got, bus.M_DATA,
                           exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            got++;
            beats++;
         end
         if (bus.M_VALID === 1'b1 && !m_ready) stalls++;
         prev_stall = (bus.M_VALID === 1'b1) && !m_ready;
         prev_data  = bus.M_DATA;
         cyc();
      end
      wr_en = 1'b0;
      total++;
      if (got != 2000 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL rnd_count: got %0d beats, %0d left, required 2000 and 0", got,
                  exp_q.size());
      end
`ifdef FIFO_RD_STATS_EN
      #1;
      total++;
      if (stat_beats !== 32'(beats) || stat_stalls !== 32'(stalls)) begin
         bad++;
         $display("FAIL rnd_stats: beats=%0d stalls=%0d required %0d/%0d", stat_beats,
                  stat_stalls, beats, stalls);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic hit = 1'b0;
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wr_en   = (i < 6);
         wr_data = 32'h50 + 32'(i);
         #1;
         if (bus.BUF_CNT === 2'd2) begin
            hit = 1'b1;
            break;
         end
         cyc();
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL mid_setup: buf_cnt=%0d required 2", bus.BUF_CNT);
      end
      wr_en    = 1'b0;
      rst      = 1'b1;
      fifo_rst = 1'b1;
      #1;
      total++;
      if (bus.FIFO_RD_EN !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_rden: got %b required 0", bus.FIFO_RD_EN);
      end
      cyc();
      rst      = 1'b0;
      fifo_rst = 1'b0;
      m_ready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (bus.M_VALID !== 1'b0 || bus.BUF_CNT !== 2'd0) begin
            bad++;
            $display("FAIL mid_after cyc%0d: valid=%b cnt=%0d required 0/0", i, bus.M_VALID,
                     bus.BUF_CNT);
         end
`ifdef FIFO_RD_STATS_EN
         total++;
         if (stat_beats !== 32'd0 || stat_stalls !== 32'd0) begin
            bad++;
            $display("FAIL mid_stats cyc%0d: beats=%0d stalls=%0d required 0/0", i, stat_beats,
                     stat_stalls);
         end
`endif
         cyc();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_latency();
      test_streaming();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
